regfile_wb_arbiter: RTL

Write-back arbiter and scoreboard for the 8 x 8-bit register file's single write port. Two producers (ALU result path and data-memory load path) compete for the write port; the block grants one per cycle with round-robin fairness and drives the register file's regWrite / write address / writeData from registers. It also tracks outstanding loads per register and blocks ALU write-backs to a destination with a pending load, so a late load cannot overwrite a newer ALU result.

---
 rtl/regfile_wb_arbiter.sv | 96 +++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter + load scoreboard for the register file's single write port (ALU vs load path).
// Latency: accept in cycle N drives regWrite/writeRegister/writeData in cycle N+1; one write per cycle.
// Backpressure: ready is combinational; ALU is held off while its destination has a load pending, both held off by holdWrite.
module regfile_wb_arbiter #(
    parameter int NREG = 8,
    parameter int AW   = 3,
    parameter int DW   = 8
) (
    input  logic            clock,
    input  logic            resetN,
    input  logic            aluValid,
    input  logic [AW-1:0]   aluDest,
    input  logic [DW-1:0]   aluData,
    output logic            aluReady,
    input  logic            memValid,
    input  logic [AW-1:0]   memDest,
    input  logic [DW-1:0]   memData,
    output logic            memReady,
    input  logic            reserveValid,
    input  logic [AW-1:0]   reserveDest,
    input  logic            holdWrite,
    output logic            regWrite,
    output logic [AW-1:0]   writeRegister,
    output logic [DW-1:0]   writeData,
    output logic [NREG-1:0] pendingMask
);

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } src_e;

    src_e            last_grant;
    logic            alu_eligible;
    logic            mem_eligible;
    logic            alu_grant;
    logic            mem_grant;
    logic [NREG-1:0] pending_nxt;

    // An ALU write to a register with a load in flight would be clobbered by the later load data.
    assign alu_eligible = aluValid && !pendingMask[aluDest];
    assign mem_eligible = memValid;

    always_comb begin
        alu_grant = 1'b0;
        mem_grant = 1'b0;
        if (!holdWrite) begin
            if (alu_eligible && mem_eligible) begin
                if (last_grant == SRC_MEM) alu_grant = 1'b1;
                else                       mem_grant = 1'b1;
            end else if (alu_eligible) begin
                alu_grant = 1'b1;
            end else if (mem_eligible) begin
                mem_grant = 1'b1;
            end
        end
    end

    assign aluReady = alu_grant;
    assign memReady = mem_grant;

    // A new reservation outranks a load retiring to the same register in the same cycle.
    always_comb begin
        pending_nxt = pendingMask;
        for (int i = 0; i < NREG; i++) begin
            if (reserveValid && (reserveDest == AW'(i))) begin
                pending_nxt[i] = 1'b1;
            end else if (mem_grant && (memDest == AW'(i))) begin
                pending_nxt[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            regWrite      <= 1'b0;
            writeRegister <= '0;
            writeData     <= '0;
            pendingMask   <= '0;
            last_grant    <= SRC_MEM;
        end else begin
            regWrite    <= alu_grant || mem_grant;
            pendingMask <= pending_nxt;
            if (alu_grant) begin
                writeRegister <= aluDest;
                writeData     <= aluData;
                last_grant    <= SRC_ALU;
            end else if (mem_grant) begin
                writeRegister <= memDest;
                writeData     <= memData;
                last_grant    <= SRC_MEM;
            end
        end
    end

endmodule
